// File: rtl/regression_coeff_engine.sv
// Streams signed Q-format (x, y) samples, accumulates regression sums, then derives the
// slope b1 and intercept b0 through one shared restoring divider. Build option: COEFF_SAT_EN.
module regression_coeff_engine #(
    parameter int DATA_W    = 20,
    parameter int FRAC_BITS = 10,
    parameter int N_SAMPLES = 150
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] x_bus,
    input  logic [DATA_W-1:0] y_bus,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              busy,
    output logic              coeff_done,
    output logic [DATA_W-1:0] b0,
    output logic [DATA_W-1:0] b1,
    output logic              div_zero,
    output logic              overflow
);
    localparam int LG    = $clog2(N_SAMPLES);
    localparam int SW    = DATA_W + LG;
    localparam int PW    = 2 * DATA_W + LG;
    localparam int NW    = 2 * SW + 2;
    localparam int TW    = DATA_W + SW + 1;
    localparam int QW    = DATA_W + 2;
    localparam int CNT_W = $clog2(N_SAMPLES + 1);
    localparam int DC_W  = $clog2(QW + 1);
    localparam int D1W   = NW + FRAC_BITS;
    localparam int C1W   = NW + DATA_W + FRAC_BITS;
    localparam int C2W   = TW + DATA_W;

    localparam logic signed [NW-1:0] N_S   = NW'(N_SAMPLES);
    localparam logic [DATA_W-1:0]    Q_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0]    Q_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, ACCUM, PREP, DIV1, B0PREP, DIV2, DONE} state_t;

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg;
    logic [DC_W-1:0]      dcnt_reg;
    logic signed [SW-1:0] sx_reg, sy_reg;
    logic signed [PW-1:0] sxx_reg, sxy_reg;
    logic [NW-1:0]        rem_reg, dsr_reg;
    logic [QW-1:0]        qlow_reg;
    logic                 neg_reg, dz_reg, ovf1_reg, ovf2_reg;
    logic [DATA_W-1:0]    b1_reg;

    logic signed [2*DATA_W-1:0] xx_c, xy_c;
    logic                       accept_c, last_c, last_div_c;

    assign xx_c       = $signed(x_bus) * $signed(x_bus);
    assign xy_c       = $signed(x_bus) * $signed(y_bus);
    assign accept_c   = (state_reg == ACCUM) && in_valid;
    assign last_c     = accept_c && (cnt_reg == CNT_W'(N_SAMPLES - 1));
    assign last_div_c = (dcnt_reg == DC_W'(QW - 1));

    // Slope numerator/denominator at full precision, split into sign and magnitude.
    logic signed [NW-1:0] num_c, den_c;
    logic [NW-1:0]        num_mag_c, den_mag_c;
    logic [D1W-1:0]       dvd1_c;
    logic                 ovf1_c;

    always_comb begin
        num_c     = N_S * NW'(sxy_reg) - NW'(sx_reg) * NW'(sy_reg);
        den_c     = N_S * NW'(sxx_reg) - NW'(sx_reg) * NW'(sx_reg);
        num_mag_c = num_c[NW-1] ? NW'(-num_c) : NW'(num_c);
        den_mag_c = den_c[NW-1] ? NW'(-den_c) : NW'(den_c);
        dvd1_c    = D1W'(num_mag_c) << FRAC_BITS;
        ovf1_c    = C1W'(dvd1_c) >= (C1W'(den_mag_c) << (DATA_W - 1));
    end

    // Intercept numerator uses the already-finalised (possibly clamped) slope.
    logic signed [DATA_W+SW-1:0] prod_c, prod_sh_c;
    logic signed [TW-1:0]        t_c;
    logic [TW-1:0]               t_mag_c;
    logic                        ovf2_c;

    always_comb begin
        prod_c    = $signed(b1_reg) * sx_reg;
        prod_sh_c = prod_c >>> FRAC_BITS;
        t_c       = TW'(sy_reg) - TW'(prod_sh_c);
        t_mag_c   = t_c[TW-1] ? TW'(-t_c) : TW'(t_c);
        ovf2_c    = C2W'(t_mag_c) >= (C2W'(N_SAMPLES) << (DATA_W - 1));
    end

    // One restoring step: dividend bits shift out of qlow_reg's top as quotient bits enter below.
    logic [NW:0]   trial_c;
    logic          ge_c;
    logic [NW-1:0] rem_step_c;
    logic [QW-1:0] q_step_c;

    always_comb begin
        trial_c    = {rem_reg, qlow_reg[QW-1]};
        ge_c       = trial_c >= {1'b0, dsr_reg};
        rem_step_c = ge_c ? NW'(trial_c - {1'b0, dsr_reg}) : NW'(trial_c);
        q_step_c   = {qlow_reg[QW-2:0], ge_c};
    end

    function automatic logic [DATA_W-1:0] finish_q(input logic [DATA_W-1:0] mag,
                                                    input logic neg, input logic ovf);
        if (ovf) begin
`ifdef COEFF_SAT_EN
            return neg ? Q_MIN : Q_MAX;
`else
            return '0;
`endif
        end
        return neg ? -mag : mag;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        busy       = 1'b1;
        coeff_done = 1'b0;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (en) state_next = ACCUM;
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (last_c) state_next = PREP;
            end
            PREP:    state_next = DIV1;
            DIV1:    if (last_div_c) state_next = B0PREP;
            B0PREP:  state_next = DIV2;
            DIV2:    if (last_div_c) state_next = DONE;
            DONE: begin
                coeff_done = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg  <= '0;
            dcnt_reg <= '0;
            sx_reg   <= '0;
            sy_reg   <= '0;
            sxx_reg  <= '0;
            sxy_reg  <= '0;
            rem_reg  <= '0;
            dsr_reg  <= '0;
            qlow_reg <= '0;
            neg_reg  <= 1'b0;
            dz_reg   <= 1'b0;
            ovf1_reg <= 1'b0;
            ovf2_reg <= 1'b0;
            b1_reg   <= '0;
            b0       <= '0;
            b1       <= '0;
            div_zero <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (en) begin
                        cnt_reg <= '0;
                        sx_reg  <= '0;
                        sy_reg  <= '0;
                        sxx_reg <= '0;
                        sxy_reg <= '0;
                    end
                end
                ACCUM: begin
                    if (accept_c) begin
                        sx_reg  <= sx_reg + SW'($signed(x_bus));
                        sy_reg  <= sy_reg + SW'($signed(y_bus));
                        sxx_reg <= sxx_reg + PW'(xx_c);
                        sxy_reg <= sxy_reg + PW'(xy_c);
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                PREP: begin
                    dz_reg   <= (den_c == '0);
                    neg_reg  <= num_c[NW-1] ^ den_c[NW-1];
                    ovf1_reg <= (den_c != '0) && ovf1_c;
                    rem_reg  <= NW'(dvd1_c >> QW);
                    qlow_reg <= dvd1_c[QW-1:0];
                    dsr_reg  <= den_mag_c;
                    dcnt_reg <= '0;
                end
                DIV1: begin
                    rem_reg  <= rem_step_c;
                    qlow_reg <= q_step_c;
                    dcnt_reg <= dcnt_reg + DC_W'(1);
                    // A zero denominator still spends the full divide time, then discards it.
                    if (last_div_c)
                        b1_reg <= dz_reg ? '0 : finish_q(q_step_c[DATA_W-1:0], neg_reg, ovf1_reg);
                end
                B0PREP: begin
                    neg_reg  <= t_c[TW-1];
                    ovf2_reg <= ovf2_c;
                    rem_reg  <= NW'(t_mag_c >> QW);
                    qlow_reg <= t_mag_c[QW-1:0];
                    dsr_reg  <= NW'(N_SAMPLES);
                    dcnt_reg <= '0;
                end
                DIV2: begin
                    rem_reg  <= rem_step_c;
                    qlow_reg <= q_step_c;
                    dcnt_reg <= dcnt_reg + DC_W'(1);
                    if (last_div_c) begin
                        b0       <= finish_q(q_step_c[DATA_W-1:0], neg_reg, ovf2_reg);
                        b1       <= b1_reg;
                        div_zero <= dz_reg;
                        overflow <= ovf1_reg | ovf2_reg;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_regression_coeff_engine.sv
// Self-checking bench for regression_coeff_engine with N_SAMPLES=4: directed scenarios plus
// randomized runs compared against a wide-integer regression model.
`timescale 1ns/1ps
module tb_regression_coeff_engine;
    localparam int DW  = 20;
    localparam int FB  = 10;
    localparam int NS  = 4;
    localparam int LAT = 2 * DW + 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic [DW-1:0] x_bus = '0;
    logic [DW-1:0] y_bus = '0;
    logic          in_valid = 1'b0;
    logic          in_ready, busy, coeff_done, div_zero, overflow;
    logic [DW-1:0] b0, b1;

    always #5 clk = ~clk;

    regression_coeff_engine #(.DATA_W(DW), .FRAC_BITS(FB), .N_SAMPLES(NS)) dut (
        .clk(clk), .rst(rst), .en(en), .x_bus(x_bus), .y_bus(y_bus), .in_valid(in_valid),
        .in_ready(in_ready), .busy(busy), .coeff_done(coeff_done), .b0(b0), .b1(b1),
        .div_zero(div_zero), .overflow(overflow)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int accept_cyc = 0;
    int xs[NS];
    int ys[NS];
    logic [DW-1:0] exp_b0, exp_b1;
    logic          exp_dz, exp_ovf;
    bit            ready_ok;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (coeff_done === 1'b1) done_cnt <= done_cnt + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Regression computed directly from the sample lists with wide signed arithmetic.
    task automatic compute_model();
        logic signed [127:0] n, sx, sy, sxx, sxy, xi, yi, num, den, q, prod, t, lim, b1v, b0v;
        n = NS; sx = 0; sy = 0; sxx = 0; sxy = 0;
        lim = 128'(1) << (DW - 1);
        for (int i = 0; i < NS; i++) begin
            xi = xs[i]; yi = ys[i];
            sx += xi; sy += yi; sxx += xi * xi; sxy += xi * yi;
        end
        num = n * sxy - sx * sy;
        den = n * sxx - sx * sx;
        exp_ovf = 1'b0;
        if (den == 0) begin
            exp_dz = 1'b1;
            b1v = 0;
        end else begin
            exp_dz = 1'b0;
            q = (num <<< FB) / den;
            if (q >= lim || q <= -lim) begin
                exp_ovf = 1'b1;
`ifdef COEFF_SAT_EN
                b1v = (q > 0) ? lim - 1 : -lim;
`else
                b1v = 0;
`endif
            end else b1v = q;
        end
        prod = b1v * sx;
        t = sy - (prod >>> FB);
        q = t / n;
        if (q >= lim || q <= -lim) begin
            exp_ovf = 1'b1;
`ifdef COEFF_SAT_EN
            b0v = (q > 0) ? lim - 1 : -lim;
`else
            b0v = 0;
`endif
        end else b0v = q;
        exp_b1 = b1v[DW-1:0];
        exp_b0 = b0v[DW-1:0];
    endtask

    // Starts a run and feeds n_send samples, optionally idling in_valid before sample stall_at.
    task automatic drive_run(input int n_send, input int stall_at, input int stall_len);
        ready_ok = 1'b1;
        en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        for (int i = 0; i < n_send; i++) begin
            if (i == stall_at) begin
                in_valid = 1'b0;
                repeat (stall_len) @(posedge clk);
                #1;
            end
            x_bus = DW'(xs[i]);
            y_bus = DW'(ys[i]);
            in_valid = 1'b1;
            if (in_ready !== 1'b1) ready_ok = 1'b0;
            @(posedge clk); #1;
            accept_cyc = cyc;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output bit got, output int lat);
        got = 1'b0;
        lat = -1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk); #1;
            if (coeff_done === 1'b1) begin
                got = 1'b1;
                lat = cyc - accept_cyc;
            end
        end
    endtask

    task automatic load_linear();
        for (int i = 0; i < NS; i++) begin
            xs[i] = 1024 * i;
            ys[i] = 2048 * i + 1024;
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, in_ready, coeff_done, div_zero, overflow} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 00000", {busy, in_ready, coeff_done, div_zero, overflow});
        end
        checks++;
        if (b0 !== '0 || b1 !== '0) begin
            errors++;
            $display("FAIL reset_coeffs: got b0=%0d b1=%0d want 0 0", b0, b1);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_linear(input int stall_len);
        bit got; int lat; int d0;
        load_linear();
        d0 = done_cnt;
        drive_run(NS, (stall_len > 0) ? 2 : -1, stall_len);
        checks++;
        if (!ready_ok || in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL linear_handshake: ready_ok=%0d in_ready=%b busy=%b want 1 0 1", ready_ok, in_ready, busy);
        end
        wait_done(got, lat);
        checks++;
        if (!got || lat != LAT) begin
            errors++;
            $display("FAIL linear_latency: got %0d want %0d", lat, LAT);
        end
        checks++;
        if (b1 !== 20'd2048 || b0 !== 20'd1024) begin
            errors++;
            $display("FAIL linear_coeffs: got b1=%0d b0=%0d want 2048 1024", $signed(b1), $signed(b0));
        end
        checks++;
        if ({div_zero, overflow} !== 2'b00) begin
            errors++;
            $display("FAIL linear_flags: got %b want 00", {div_zero, overflow});
        end
        @(posedge clk); #1;
        checks++;
        if (coeff_done !== 1'b0 || busy !== 1'b0 || b1 !== 20'd2048 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL linear_after: done=%b busy=%b b1=%0d pulses=%0d want 0 0 2048 1",
                     coeff_done, busy, $signed(b1), done_cnt - d0);
        end
        $display("linear stall=%0d: b1=%0d b0=%0d lat=%0d", stall_len, $signed(b1), $signed(b0), lat);
    endtask

    task automatic test_div_zero();
        bit got; int lat;
        for (int i = 0; i < NS; i++) begin
            xs[i] = 2048;
            ys[i] = 1024 * (i + 1);
        end
        drive_run(NS, -1, 0);
        wait_done(got, lat);
        checks++;
        if (!got || b1 !== '0 || b0 !== 20'd2560 || div_zero !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL div_zero: got b1=%0d b0=%0d dz=%b ovf=%b want 0 2560 1 0",
                     $signed(b1), $signed(b0), div_zero, overflow);
        end
        $display("div_zero: b1=%0d b0=%0d dz=%b", $signed(b1), $signed(b0), div_zero);
        @(posedge clk); #1;
    endtask

    task automatic test_overflow();
        bit got; int lat;
        logic [DW-1:0] want_b1, want_b0;
        xs[0] = 0; xs[1] = 1; xs[2] = 0; xs[3] = 0;
        ys[0] = 0; ys[1] = 262143; ys[2] = 0; ys[3] = 0;
`ifdef COEFF_SAT_EN
        want_b1 = 20'd524287; want_b0 = 20'd65408;
`else
        want_b1 = 20'd0;      want_b0 = 20'd65535;
`endif
        drive_run(NS, -1, 0);
        wait_done(got, lat);
        checks++;
        if (!got || b1 !== want_b1 || b0 !== want_b0 || overflow !== 1'b1 || div_zero !== 1'b0) begin
            errors++;
            $display("FAIL overflow: got b1=%0d b0=%0d ovf=%b dz=%b want %0d %0d 1 0",
                     $signed(b1), $signed(b0), overflow, div_zero, $signed(want_b1), $signed(want_b0));
        end
        $display("overflow: b1=%0d b0=%0d ovf=%b", $signed(b1), $signed(b0), overflow);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midrun();
        int d0;
        load_linear();
        drive_run(2, -1, 0);
        rst = 1'b0;
        #1;
        checks++;
        if ({busy, in_ready, div_zero, overflow} !== 4'b0 || b0 !== '0 || b1 !== '0) begin
            errors++;
            $display("FAIL midrun_reset: busy=%b rdy=%b b0=%0d b1=%0d want all zero", busy, in_ready, b0, b1);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        d0 = done_cnt;
        repeat (60) @(posedge clk);
        #1;
        checks++;
        if (done_cnt != d0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrun_abort: pulses=%0d busy=%b want 0 0", done_cnt - d0, busy);
        end
        test_linear(0);
    endtask

    task automatic test_en_during_div();
        bit got; int lat; int d0;
        load_linear();
        d0 = done_cnt;
        drive_run(NS, -1, 0);
        repeat (5) @(posedge clk);
        #1;
        en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL en_in_div_state: busy=%b rdy=%b want 1 0", busy, in_ready);
        end
        wait_done(got, lat);
        checks++;
        if (!got || lat != LAT || b1 !== 20'd2048 || b0 !== 20'd1024) begin
            errors++;
            $display("FAIL en_in_div_result: lat=%0d b1=%0d b0=%0d want %0d 2048 1024",
                     lat, $signed(b1), $signed(b0), LAT);
        end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (done_cnt - d0 != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL en_in_div_pulses: pulses=%0d busy=%b want 1 0", done_cnt - d0, busy);
        end
    endtask

    task automatic test_back_to_back();
        bit got; int lat; int a;
        for (int r = 0; r < 24; r++) begin
            a = int'($urandom_range(0, 8)) - 4;
            for (int i = 0; i < NS; i++) begin
                case (r % 3)
                    0: begin
                        xs[i] = int'($urandom_range(0, 1048575)) - 524288;
                        ys[i] = int'($urandom_range(0, 1048575)) - 524288;
                    end
                    1: begin
                        xs[i] = int'($urandom_range(0, 4095)) - 2048;
                        ys[i] = int'($urandom_range(0, 4095)) - 2048;
                    end
                    default: begin
                        xs[i] = int'($urandom_range(0, 2047)) - 1024;
                        ys[i] = a * xs[i] + int'($urandom_range(0, 255)) - 128;
                    end
                endcase
                if (r == 7) xs[i] = xs[0];
            end
            compute_model();
            drive_run(NS, -1, 0);
            wait_done(got, lat);
            checks++;
            if (!got || lat != LAT) begin
                errors++;
                $display("FAIL rand%0d_latency: got %0d want %0d", r, lat, LAT);
            end
            checks++;
            if (b1 !== exp_b1 || b0 !== exp_b0 || div_zero !== exp_dz || overflow !== exp_ovf) begin
                errors++;
                $display("FAIL rand%0d_coeffs: got b1=%0d b0=%0d dz=%b ovf=%b want %0d %0d %b %b", r,
                         $signed(b1), $signed(b0), div_zero, overflow,
                         $signed(exp_b1), $signed(exp_b0), exp_dz, exp_ovf);
            end
            $display("rand %0d: b1=%0d b0=%0d dz=%b ovf=%b", r, $signed(b1), $signed(b0), div_zero, overflow);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_linear(0);
        test_linear(7);
        test_div_zero();
        test_overflow();
        test_reset_midrun();
        test_en_during_div();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
